// File: rtl/filter_glb_read_pkg.sv
// Shared types for the filter GLB read controller:
// controller states and the NoC FIFO entry layout.
package filter_glb_read_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int ENT_DATA_W = 16;
  localparam int ENT_ROW_W  = 4;
  localparam int ENT_COL_W  = 8;

  typedef struct packed {
    logic [ENT_DATA_W-1:0] data;
    logic [ENT_ROW_W-1:0]  row_id;
    logic [ENT_COL_W-1:0]  col_id;
  } fifo_entry_t;

endpackage

// File: rtl/filter_noc_fifo.sv
// Show-ahead FIFO feeding the filter NoC; head entry is
// always visible on pop_data, occupancy exposed as count.
module filter_noc_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 28,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign do_pop   = pop && !empty;
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/filter_glb_read_controller.sv
// Turns filter index tuples into GLB weight reads and pushes
// tagged weights to the filter NoC under a credit throttle.
module filter_glb_read_controller
  import filter_glb_read_pkg::*;
#(
  parameter int M_IDX_WIDTH = 8,
  parameter int C_IDX_WIDTH = 5,
  parameter int R_WIDTH     = 4,
  parameter int S_WIDTH     = 6,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [C_IDX_WIDTH-1:0] C,
  input  logic [R_WIDTH-1:0]     R,
  input  logic [S_WIDTH-1:0]     S,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic                   idx_valid,
  input  logic [M_IDX_WIDTH-1:0] filter_index,
  input  logic [C_IDX_WIDTH-1:0] channel_index,
  input  logic [R_WIDTH-1:0]     row_index,
  input  logic [S_WIDTH-1:0]     col_index,
  input  logic                   gen_done,
  output logic                   await,
  output logic                   glb_rd_en,
  output logic [ADDR_WIDTH-1:0]  glb_rd_addr,
  input  logic [DATA_WIDTH-1:0]  glb_rd_data,
  output logic                   noc_valid,
  input  logic                   noc_ready,
  output logic [DATA_WIDTH-1:0]  noc_data,
  output logic [R_WIDTH-1:0]     noc_row_id,
  output logic [M_IDX_WIDTH-1:0] noc_col_id,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = $bits(fifo_entry_t);

  state_t state, state_nxt;

  logic [4:0]             vld;
  logic [M_IDX_WIDTH-1:0] fid [5];
  logic [R_WIDTH-1:0]     rid [5];
  logic [C_IDX_WIDTH-1:0] ch0;
  logic [S_WIDTH-1:0]     col0, col1, col2;
  logic [ADDR_WIDTH-1:0]  t1, t2;
  logic [2:0]             inflight;
  logic                   accept;

  fifo_entry_t   push_ent, pop_ent;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  assign inflight = 3'($countones(vld));
  // Credit check sees only registered state, so it never loops.
  assign await = (int'(fifo_count) + int'(inflight) >= FIFO_DEPTH)
              || (state != RUN);
  assign accept = (state == RUN) && idx_valid && !await;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld         <= '0;
      ch0         <= '0;
      col0        <= '0;
      col1        <= '0;
      col2        <= '0;
      t1          <= '0;
      t2          <= '0;
      glb_rd_addr <= '0;
      for (int i = 0; i < 5; i++) begin
        fid[i] <= '0;
        rid[i] <= '0;
      end
    end else begin
      vld <= {vld[3:0], accept};
      if (accept) begin
        fid[0] <= filter_index;
        rid[0] <= row_index;
        ch0    <= channel_index;
        col0   <= col_index;
      end
      if (vld[0])
        t1 <= ADDR_WIDTH'(fid[0]) * ADDR_WIDTH'(C)
            + ADDR_WIDTH'(ch0);
      if (vld[1])
        t2 <= t1 * ADDR_WIDTH'(R) + ADDR_WIDTH'(rid[1]);
      if (vld[2])
        glb_rd_addr <= base_addr + t2 * ADDR_WIDTH'(S)
                     + ADDR_WIDTH'(col2);
      col1 <= col0;
      col2 <= col1;
      for (int i = 1; i < 5; i++) begin
        fid[i] <= fid[i-1];
        rid[i] <= rid[i-1];
      end
    end
  end

  assign glb_rd_en = vld[3];

  always_comb begin
    push_ent        = '0;
    push_ent.data   = ENT_DATA_W'(glb_rd_data);
    push_ent.row_id = ENT_ROW_W'(rid[4]);
    push_ent.col_id = ENT_COL_W'(fid[4]);
  end

  filter_noc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (vld[4]),
    .push_data (push_ent),
    .pop       (noc_valid && noc_ready),
    .pop_data  (pop_ent),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign noc_valid  = !fifo_empty;
  assign noc_data   = noc_valid ? DATA_WIDTH'(pop_ent.data)   : '0;
  assign noc_row_id = noc_valid ? R_WIDTH'(pop_ent.row_id)    : '0;
  assign noc_col_id = noc_valid ? M_IDX_WIDTH'(pop_ent.col_id) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (gen_done) state_nxt = DRAIN;
      DRAIN:   if (inflight == '0 && fifo_empty) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: doc/filter_glb_read_controller.md
# filter_glb_read_controller

Consumes the (filter, channel, row, column) index stream from the filter index generator and turns it into filter-weight reads from the global buffer (GLB). Returned weights go onto the filter NoC, tagged with a row ID and a column ID. The block throttles the generator through `await`, so the pipeline never stalls internally, and it signals completion once the last weight has left.

## Interface
- `M_IDX_WIDTH`, default 8: filter_index width (p_WIDTH + t_WIDTH).
- `C_IDX_WIDTH`, default 5: channel_index width (q_WIDTH + r_WIDTH).
- `R_WIDTH`, default 4: row_index width.
- `S_WIDTH`, default 6: col_index width.
- `ADDR_WIDTH`, default 16: GLB address width.
- `DATA_WIDTH`, default 16: weight width.
- `FIFO_DEPTH`, default 8: output FIFO entries (power of two).

Ports:
- `clk`  in  1  clock; all registers update on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle arm pulse, issued together with the generator's start.
- `C`  in  C_IDX_WIDTH  total channels in the pass.
- `R`  in  R_WIDTH  filter rows.
- `S`  in  S_WIDTH  filter columns.
- `base_addr`  in  ADDR_WIDTH  GLB base of the filter tensor.
- `idx_valid`  in  1  generator busy; one index tuple offered.
- `filter_index`  in  M_IDX_WIDTH  filter index from the generator.
- `channel_index`  in  C_IDX_WIDTH  channel index from the generator.
- `row_index`  in  R_WIDTH  row index from the generator.
- `col_index`  in  S_WIDTH  column index from the generator.
- `gen_done`  in  1  generator done pulse.
- `await`  out  1  stall request to the generator.
- `glb_rd_en`  out  1  GLB read strobe.
- `glb_rd_addr`  out  ADDR_WIDTH  GLB read address.
- `glb_rd_data`  in  DATA_WIDTH  read data, valid exactly one cycle after `glb_rd_en`.
- `noc_valid`  out  1  NoC output valid.
- `noc_ready`  in  1  NoC output ready.
- `noc_data`  out  DATA_WIDTH  weight.
- `noc_row_id`  out  R_WIDTH  row tag (row_index).
- `noc_col_id`  out  M_IDX_WIDTH  column tag (filter_index).
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states and transitions:
  - IDLE → RUN on `start`.
  - RUN → DRAIN when `gen_done` is sampled.
  - DRAIN → DONE when `inflight==0` and the FIFO is empty.
  - DONE → IDLE unconditionally; `done=1` in the DONE state.
  - If `gen_done` arrives while already drained, DONE follows in the very next cycle.
- Acceptance rule: an index tuple is accepted only when the state is RUN and `idx_valid && !await`. In IDLE, DRAIN and DONE, `await=1` and `idx_valid` is ignored.
- Address computation, pipelined across three registered stages:
  - S1: `t1 = filter_index*C + channel_index`
  - S2: `t2 = t1*R + row_index`
  - S3: `glb_rd_addr = base_addr + t2*S + col_index`
- Address width: all arithmetic is in ADDR_WIDTH and wraps modulo 2^ADDR_WIDTH.
- Tag carriage: the row and filter tags travel alongside the pipeline stages.
- Stage S4 captures `glb_rd_data` and pushes `{data, row_id, col_id}` into the FIFO.
- Credit rule:
  - `inflight` = number of valid bits in stages S0..S4.
  - `await = (fifo_count + inflight >= FIFO_DEPTH) || state != RUN`.
  - `await` is combinational from registered values only.
  - Hence the FIFO never overflows and the pipeline never stalls.
- FIFO is show-ahead: `noc_valid = !empty`. A pop happens on `noc_valid && noc_ready`.
- Simultaneous push and pop: `fifo_count` is unchanged and the data order is preserved.
- Configuration inputs (`C`, `R`, `S`, `base_addr`) must be held stable from `start` until `done`.

## Timing
- Reset values: all outputs 0 except `await=1`; FSM in IDLE, FIFO empty, all valid bits clear.
- Acceptance edge is edge 0.
- `glb_rd_en` and `glb_rd_addr` are registered at edge 3 and high for one cycle.
- FIFO write at edge 5, so `noc_valid` rises after edge 5 when the FIFO was empty.
- Sustained throughput: one tuple per cycle while `noc_ready=1`.
- `done` rises on the edge after the final pop, and only if `gen_done` has already been seen.
- Reset asserted mid-operation:
  - Immediately clears all state.
  - In-flight reads are discarded.
  - Any GLB data returning afterwards is ignored.

## Structure
- Package `filter_glb_read_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the FIFO entry struct (data, row_id, col_id).
- Sub-module `filter_noc_fifo`: synchronous show-ahead FIFO, parameterised by depth and entry width, exposing a count.
- All other logic lives in the top level.

## Test plan
- Reset: `reset=0` → all outputs 0, `await=1`; after release, `await` stays 1 until `start`.
- Single tuple:
  - Stimulus: C=3, R=3, S=3, base=0x0100, tuple (1,2,1,2), `glb_rd_data=0xBEEF`.
  - Expected: `glb_rd_en` after edge 3 with addr 0x0132; then `noc_data=0xBEEF`, `row_id=1`, `col_id=1` after edge 5.
- Backpressure:
  - Stimulus: `noc_ready=0`, continuous `idx_valid`.
  - Expected: exactly 8 accepts, then `await=1`.
  - Then: set `noc_ready=1` → 8 pops in order, acceptance resumes with no loss or duplication.
- Address wrap: base=0xFFFF, offset 2 → `glb_rd_addr=0x0001`.
- Completion:
  - Stimulus: `gen_done` with 3 tuples in flight and `noc_ready=1`.
  - Expected: exactly one `done` pulse, on the edge after the 3rd pop.
- Mid-stream reset: assert `reset` with 5 tuples in flight → immediate clear, no `noc_valid`, `await=1`.
